relu_grad_stream: RTL
=====================

# relu_grad_stream

Streaming ReLU unit with both passes: the forward path registers ReLU of IEEE-754 single-precision activations and records one "was positive" mask bit per element in an internal FIFO. The backward path consumes those mask bits in the same element order to gate incoming top gradients into bottom gradients (bottom_diff = top_diff when bottom_data > 0, else +0.0). It sits between a convolution/FC layer and its backward-pass gradient engine. Element order is identical in both passes, so no address bookkeeping is needed.

## Interface
- DEPTH, 1024: mask FIFO entries; power of two, ≥ 2.
- CW, $clog2(DEPTH)+1: width of mask_count.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mask_clear  in  1  synchronous flush of the mask FIFO.
- fwd_in_valid / fwd_in_ready  in / out  1  forward input handshake.
- fwd_in_data  in  32  forward activation (float).
- fwd_out_valid / fwd_out_ready  out / in  1  forward output handshake.
- fwd_out_data  out  32  ReLU result (float).
- bwd_in_valid / bwd_in_ready  in / out  1  backward input handshake.
- bwd_in_diff  in  32  top gradient (float).
- bwd_out_valid / bwd_out_ready  out / in  1  backward output handshake.
- bwd_out_diff  out  32  bottom gradient (float).
- mask_count  out  CW  stored mask bits, 0..DEPTH.
- mask_full / mask_empty  out  1  mask_count == DEPTH / == 0.

## Operation
- Transfer occurs on a channel when valid && ready at a rising edge. Valid must not depend on ready.
- Positive test: pos(x) = !x[31] && (x[30:0] != 0) && !(x[30:23] == 8'hFF && x[22:0] != 0).
  - +0, -0, every negative value, and every NaN are non-positive.
  - +Inf is positive.
- Forward:
  - fwd_in_ready = (!fwd_out_valid || fwd_out_ready) && !mask_full && !mask_clear.
  - On transfer: fwd_out_data <= pos(x) ? x : 32'h0, fwd_out_valid <= 1, and pos(x) is pushed to the mask FIFO.
- Backward:
  - bwd_in_ready = (!bwd_out_valid || bwd_out_ready) && !mask_empty && !mask_clear.
  - On transfer: pop the oldest mask bit m, bwd_out_diff <= m ? d : 32'h0, bwd_out_valid <= 1.
  - The diff passes unmodified (sign, NaN payload), including negative gradients.
- Output valid registers clear on an output transfer that has no new input transfer in the same cycle.
- Simultaneous push and pop: both occur and mask_count is unchanged.
- No bypass: when empty, a pop cannot consume a bit pushed in the same cycle.
- Full FIFO: fwd_in_ready = 0 even if a pop occurs in that cycle.
- mask_clear:
  - Resets the FIFO pointers and count next cycle.
  - Wins over any push or pop in the same cycle (both readies are forced low).
  - Output registers and their pending valid data are unaffected.
- Pointers are log2(DEPTH) bits wide and wrap naturally. The count is tracked separately.

## Timing
- Reset values (asynchronous assert): fwd_out_valid = 0, bwd_out_valid = 0, fwd_out_data = 0, bwd_out_diff = 0, pointers = 0, mask_count = 0, mask_empty = 1, mask_full = 0.
- After reset deassertion, operation starts on the first rising edge; no warm-up cycles.
- Latency on both paths: 1 cycle from input transfer to output valid.
- Throughput: 1 element per cycle per path, concurrently.
- Output data and valid hold stable while valid && !ready.
- mask_count, mask_full, mask_empty are registered and reflect transfers from the previous edge.
- Reset mid-stream discards all pending outputs and mask bits.

## Structure
- Shared package relu_pkg: the float width constant FP_W = 32, the FLOAT_ZERO constant, and the pos() function as is_positive_f32. The existing ReLU blocks migrate to it.
- Sub-module sign_mask_fifo: 1-bit-wide synchronous FIFO with DEPTH, push, pop, clear, count, full, empty.
  - Implemented as a register array or inferred RAM with registered read.
  - Read latency is hidden by a prefetched head bit.

## Test plan
- Reset with all valids high:
  - During reset: all outputs at reset values, mask_empty = 1.
  - After release: first forward transfer of 0x3F800000 gives fwd_out_data = 0x3F800000 next cycle.
- Forward [0x3F800000, 0xBF800000, 0x00000000, 0x80000000, 0x7FC00000, 0x7F800000]:
  - fwd_out = [0x3F800000, 0, 0, 0, 0, 0x7F800000], mask_count = 6.
  - Backward six diffs of 0xC0000000: bwd_out = [0xC0000000, 0, 0, 0, 0, 0xC0000000], mask_empty = 1.
- DEPTH = 4, push 4 elements:
  - fwd_in_ready = 0 and mask_full = 1.
  - Pop 1: readiness returns the following cycle.
  - Backward on empty: bwd_in_ready = 0 even with a simultaneous push.
- Continuous streams with random ready stalls on both outputs:
  - Every output matches the golden model in order, with no drops or duplicates.
  - During simultaneous push/pop, mask_count stays constant.
- Push 3 elements, then assert mask_clear together with fwd_in_valid and bwd_in_valid:
  - Both readies are 0 in that cycle.
  - Next cycle mask_count = 0, and the pending fwd_out_data is still presented until accepted.

Source files
------------

// File: rtl/relu_pkg.sv
// Shared float helpers for the ReLU forward/backward blocks.
package relu_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [MAN_W-1:0] mantissa;
    } f32_t;

    localparam logic [FP_W-1:0] FLOAT_ZERO = '0;

    // Strictly greater than zero: rejects both zeros, negatives and NaNs; +Inf passes.
    function automatic logic is_positive_f32(input logic [FP_W-1:0] x);
        f32_t f;
        logic is_nan;
        f      = f32_t'(x);
        is_nan = (f.exponent == '1) && (f.mantissa != '0);
        return !f.sign && ({f.exponent, f.mantissa} != '0) && !is_nan;
    endfunction

endpackage

// File: rtl/sign_mask_fifo.sv
// 1-bit FIFO holding per-element "was positive" flags; head bit is prefetched
// into a register so a pop sees its bit with no read latency.
module sign_mask_fifo #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          push_bit,
    input  logic          pop,
    output logic          head_bit,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             head_q, head_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        do_push  = push && !full_q && !clear;
        do_pop   = pop && !empty_q && !clear;
        rd_next  = rd_ptr_q + AW'(1);

        if (do_push) begin
            mem_d[wr_ptr_q] = push_bit;
        end

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_next;
            if (do_push && !do_pop) count_d = count_q + CW'(1);
            if (do_pop && !do_push) count_d = count_q - CW'(1);
        end

        // Next head comes from storage, or straight from the write port when
        // the element being pushed lands exactly behind the one popped.
        if (do_pop) begin
            head_d = (do_push && count_q == CW'(1)) ? push_bit : mem_q[rd_next];
        end else if (do_push && empty_q) begin
            head_d = push_bit;
        end

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    assign head_bit = head_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/relu_grad_stream.sv
// Streaming ReLU: forward pass records sign masks, backward pass replays them
// in order to gate top gradients into bottom gradients.
module relu_grad_stream
    import relu_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mask_clear,
    input  logic            fwd_in_valid,
    output logic            fwd_in_ready,
    input  logic [FP_W-1:0] fwd_in_data,
    output logic            fwd_out_valid,
    input  logic            fwd_out_ready,
    output logic [FP_W-1:0] fwd_out_data,
    input  logic            bwd_in_valid,
    output logic            bwd_in_ready,
    input  logic [FP_W-1:0] bwd_in_diff,
    output logic            bwd_out_valid,
    input  logic            bwd_out_ready,
    output logic [FP_W-1:0] bwd_out_diff,
    output logic [CW-1:0]   mask_count,
    output logic            mask_full,
    output logic            mask_empty
);

    logic            fwd_out_valid_q, fwd_out_valid_d;
    logic [FP_W-1:0] fwd_out_data_q, fwd_out_data_d;
    logic            bwd_out_valid_q, bwd_out_valid_d;
    logic [FP_W-1:0] bwd_out_diff_q, bwd_out_diff_d;
    logic            fwd_pos;
    logic            push, pop;
    logic            mask_head;

    assign fwd_pos      = is_positive_f32(fwd_in_data);
    assign fwd_in_ready = (!fwd_out_valid_q || fwd_out_ready) && !mask_full && !mask_clear;
    assign bwd_in_ready = (!bwd_out_valid_q || bwd_out_ready) && !mask_empty && !mask_clear;
    assign push         = fwd_in_valid && fwd_in_ready;
    assign pop          = bwd_in_valid && bwd_in_ready;

    sign_mask_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_mask_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (mask_clear),
        .push     (push),
        .push_bit (fwd_pos),
        .pop      (pop),
        .head_bit (mask_head),
        .count    (mask_count),
        .full     (mask_full),
        .empty    (mask_empty)
    );

    // Output skid-free registers: load on input transfer, drop valid when drained.
    always_comb begin
        fwd_out_valid_d = fwd_out_valid_q;
        fwd_out_data_d  = fwd_out_data_q;
        bwd_out_valid_d = bwd_out_valid_q;
        bwd_out_diff_d  = bwd_out_diff_q;

        if (push) begin
            fwd_out_valid_d = 1'b1;
            fwd_out_data_d  = fwd_pos ? fwd_in_data : FLOAT_ZERO;
        end else if (fwd_out_ready) begin
            fwd_out_valid_d = 1'b0;
        end

        if (pop) begin
            bwd_out_valid_d = 1'b1;
            bwd_out_diff_d  = mask_head ? bwd_in_diff : FLOAT_ZERO;
        end else if (bwd_out_ready) begin
            bwd_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_out_valid_q <= 1'b0;
            fwd_out_data_q  <= FLOAT_ZERO;
            bwd_out_valid_q <= 1'b0;
            bwd_out_diff_q  <= FLOAT_ZERO;
        end else begin
            fwd_out_valid_q <= fwd_out_valid_d;
            fwd_out_data_q  <= fwd_out_data_d;
            bwd_out_valid_q <= bwd_out_valid_d;
            bwd_out_diff_q  <= bwd_out_diff_d;
        end
    end

    assign fwd_out_valid = fwd_out_valid_q;
    assign fwd_out_data  = fwd_out_data_q;
    assign bwd_out_valid = bwd_out_valid_q;
    assign bwd_out_diff  = bwd_out_diff_q;

endmodule
